// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frames leave back-to-back while words are queued.
// Data bits, parity, stop bits, bit period and FIFO depth are compile-time parameters.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             bit_q, bit_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         level_q, level_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic                   div_wrap;
  logic [DATA_BITS-1:0]   head;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    if (PARITY == 1) begin
      return ~^w;
    end
    return ^w;
  endfunction

  assign in_ready   = (level_q != LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign div_wrap   = (div_q == DIV_LAST);

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        bit_d  = '0;
        pop    = !fifo_empty;
      end
      S_START: begin
        if (div_wrap) begin
          div_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_wrap) begin
          div_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_PAR: begin
        if (div_wrap) begin
          div_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_STOP: begin
        if (div_wrap) begin
          div_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (fifo_empty) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              pop = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pop loads the next word and starts its frame on the same edge, with no idle gap.
    if (pop) begin
      shift_d = head;
      par_d   = parity_of(head);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      div_d   = '0;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Datapath storage carries no reset; the control state above decides what is valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
